// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_bus_pkg
// Description : Shared constants and types for the unified-memory port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_bus_pkg;

    localparam int DEFAULT_ADDR_W = 32;
    localparam int DEFAULT_DATA_W = 32;
    localparam int TO_W           = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_BUSY = ST_BUSY,
        S_RESP = ST_RESP
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter_if
// Description : Two master ports plus the memory-side handshake of the arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_port_arbiter_if
    import mem_bus_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int DATA_W = DEFAULT_DATA_W
);
    logic              m0_req;
    logic              m0_we;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_wdata;
    logic              m0_ack;
    logic              m0_err;
    logic [DATA_W-1:0] m0_rdata;

    logic              m1_req;
    logic              m1_we;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wdata;
    logic              m1_ack;
    logic              m1_err;
    logic [DATA_W-1:0] m1_rdata;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    // Arbiter view
    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        output m0_ack, m0_err, m0_rdata,
        input  m1_req, m1_we, m1_addr, m1_wdata,
        output m1_ack, m1_err, m1_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata
    );

    // Environment view: masters and memory
    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        input  m0_ack, m0_err, m0_rdata,
        output m1_req, m1_we, m1_addr, m1_wdata,
        input  m1_ack, m1_err, m1_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rdata
    );

endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter_rr_arbiter2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter2
// Description : Two-input round-robin grant; a tie goes to the master not served last.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter2 (
    input  wire logic [1:0] req,
    input  wire logic       last_grant,
    output logic            gnt_valid,
    output logic            gnt_idx
);

    always_comb begin
        gnt_valid = |req;
        if (req == 2'b11) begin
            gnt_idx = ~last_grant;
        end else begin
            gnt_idx = req[1];
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Round-robin sharing of the single-ported memory between two masters.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import mem_bus_pkg::*;
#(
    parameter int ADDR_W  = DEFAULT_ADDR_W,
    parameter int DATA_W  = DEFAULT_DATA_W,
    parameter int TIMEOUT = 255
) (
    input  wire logic          clk,
    input  wire logic          rst,
    mem_port_arbiter_if.slave  bus,
    output logic               busy,
    output logic               owner
);

    localparam logic [TO_W-1:0] c_TO_LAST = TO_W'(TIMEOUT - 1);

    state_t            r_state;
    logic              r_last_grant;
    logic [TO_W-1:0]   r_cnt;
    logic              r_mem_req;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_ack0;
    logic              r_ack1;
    logic              r_err0;
    logic              r_err1;
    logic [DATA_W-1:0] r_rdata0;
    logic [DATA_W-1:0] r_rdata1;

    logic              w_gnt_valid;
    logic              w_gnt_idx;
    logic              w_we;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;

    rr_arbiter2 u_rr_arbiter2 (
        .req        ({bus.m1_req, bus.m0_req}),
        .last_grant (r_last_grant),
        .gnt_valid  (w_gnt_valid),
        .gnt_idx    (w_gnt_idx)
    );

    assign w_we    = w_gnt_idx ? bus.m1_we    : bus.m0_we;
    assign w_addr  = w_gnt_idx ? bus.m1_addr  : bus.m0_addr;
    assign w_wdata = w_gnt_idx ? bus.m1_wdata : bus.m0_wdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_last_grant <= 1'b1;
            r_cnt        <= '0;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_ack0       <= 1'b0;
            r_ack1       <= 1'b0;
            r_err0       <= 1'b0;
            r_err1       <= 1'b0;
            r_rdata0     <= '0;
            r_rdata1     <= '0;
            busy         <= 1'b0;
            owner        <= 1'b0;
        end else begin
            // Completion flags are single-cycle pulses
            r_ack0 <= 1'b0;
            r_ack1 <= 1'b0;
            r_err0 <= 1'b0;
            r_err1 <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_gnt_valid) begin
                        r_mem_req    <= 1'b1;
                        r_mem_we     <= w_we;
                        r_mem_addr   <= w_addr;
                        r_mem_wdata  <= w_wdata;
                        owner        <= w_gnt_idx;
                        r_last_grant <= w_gnt_idx;
                        r_cnt        <= '0;
                        busy         <= 1'b1;
                        r_state      <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    // An ack on the final timeout cycle takes priority over the abort
                    if (bus.mem_ack) begin
                        r_mem_req <= 1'b0;
                        if (owner) begin
                            r_ack1   <= 1'b1;
                            r_rdata1 <= bus.mem_rdata;
                        end else begin
                            r_ack0   <= 1'b1;
                            r_rdata0 <= bus.mem_rdata;
                        end
                        r_state <= S_RESP;
                    end else if (r_cnt == c_TO_LAST) begin
                        r_mem_req <= 1'b0;
                        if (owner) begin
                            r_ack1   <= 1'b1;
                            r_err1   <= 1'b1;
                            r_rdata1 <= '0;
                        end else begin
                            r_ack0   <= 1'b1;
                            r_err0   <= 1'b1;
                            r_rdata0 <= '0;
                        end
                        r_state <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt + TO_W'(1);
                    end
                end
                S_RESP: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_mem_req <= 1'b0;
                    busy      <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.mem_req   = r_mem_req;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.m0_ack    = r_ack0;
    assign bus.m0_err    = r_err0;
    assign bus.m0_rdata  = r_rdata0;
    assign bus.m1_ack    = r_ack1;
    assign bus.m1_err    = r_err1;
    assign bus.m1_rdata  = r_rdata1;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Directed self-checking bench for mem_port_arbiter (TIMEOUT=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    logic clk;
    logic rst;
    logic busy;
    logic owner;
    int   checks;
    int   failures;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_port_arbiter #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .TIMEOUT (8)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus),
        .busy  (busy),
        .owner (owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks   = 0;
        failures = 0;
        rst = 1'b1;
        bus.m0_req = 1'b0; bus.m0_we = 1'b0; bus.m0_addr = '0; bus.m0_wdata = '0;
        bus.m1_req = 1'b0; bus.m1_we = 1'b0; bus.m1_addr = '0; bus.m1_wdata = '0;
        bus.mem_ack = 1'b0; bus.mem_rdata = '0;
        tick(); tick();

        // Reset state
        check("rst_mem_req", bus.mem_req, 0);
        check("rst_busy",    busy,        0);
        check("rst_owner",   owner,       0);
        check("rst_m0_ack",  bus.m0_ack,  0);
        check("rst_m1_ack",  bus.m1_ack,  0);
        check("rst_m0_rdata", bus.m0_rdata, 0);
        rst = 1'b0;

        // Contention: both masters request continuously, memory acks after 1 cycle
        bus.m0_req = 1'b1; bus.m0_addr = 32'h100;
        bus.m1_req = 1'b1; bus.m1_addr = 32'h300;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("cont_mem_req", bus.mem_req, 1);
            check("cont_owner",   owner, k % 2);
            check("cont_addr",    bus.mem_addr, (k % 2 == 1) ? 32'h300 : 32'h100);
            bus.mem_ack = 1'b1; bus.mem_rdata = 32'h1000 + k;
            tick();
            bus.mem_ack = 1'b0;
            check("cont_m0_ack", bus.m0_ack, (k % 2 == 0) ? 1 : 0);
            check("cont_m1_ack", bus.m1_ack, (k % 2 == 1) ? 1 : 0);
            check("cont_rdata",  (k % 2 == 1) ? bus.m1_rdata : bus.m0_rdata, 32'h1000 + k);
            check("cont_req_drop", bus.mem_req, 0);
            tick();
            check("cont_m0_ack_clr", bus.m0_ack, 0);
            check("cont_m1_ack_clr", bus.m1_ack, 0);
            check("cont_idle_busy",  busy, 0);
        end
        bus.m0_req = 1'b0; bus.m1_req = 1'b0;
        tick();

        // Single read from master 0, memory acks in the 3rd BUSY cycle
        bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = 32'h10;
        tick();
        check("rd_mem_req_c1", bus.mem_req, 1);
        check("rd_mem_addr",   bus.mem_addr, 32'h10);
        check("rd_busy",       busy, 1);
        check("rd_owner",      owner, 0);
        tick();
        check("rd_mem_req_c2", bus.mem_req, 1);
        tick();
        check("rd_mem_req_c3", bus.mem_req, 1);
        check("rd_no_ack_yet", bus.m0_ack, 0);
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'hDEADBEEF;
        tick();
        bus.mem_ack = 1'b0; bus.m0_req = 1'b0;
        check("rd_mem_req_drop", bus.mem_req, 0);
        check("rd_m0_ack",   bus.m0_ack, 1);
        check("rd_m0_err",   bus.m0_err, 0);
        check("rd_m0_rdata", bus.m0_rdata, 32'hDEADBEEF);
        check("rd_m1_ack",   bus.m1_ack, 0);
        check("rd_resp_busy", busy, 1);
        tick();
        check("rd_ack_clr",   bus.m0_ack, 0);
        check("rd_idle_busy", busy, 0);
        check("rd_rdata_hold", bus.m0_rdata, 32'hDEADBEEF);

        // Write from master 1
        bus.m1_req = 1'b1; bus.m1_we = 1'b1; bus.m1_addr = 32'h200; bus.m1_wdata = 32'h12345678;
        tick();
        check("wr_mem_req",   bus.mem_req, 1);
        check("wr_mem_we",    bus.mem_we, 1);
        check("wr_mem_addr",  bus.mem_addr, 32'h200);
        check("wr_mem_wdata", bus.mem_wdata, 32'h12345678);
        check("wr_owner",     owner, 1);
        tick();
        check("wr_hold_we",    bus.mem_we, 1);
        check("wr_hold_addr",  bus.mem_addr, 32'h200);
        check("wr_hold_wdata", bus.mem_wdata, 32'h12345678);
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'hA5A5A5A5;
        tick();
        bus.mem_ack = 1'b0; bus.m1_req = 1'b0; bus.m1_we = 1'b0;
        check("wr_m1_ack",   bus.m1_ack, 1);
        check("wr_m1_err",   bus.m1_err, 0);
        check("wr_m0_ack",   bus.m0_ack, 0);
        check("wr_m1_rdata", bus.m1_rdata, 32'hA5A5A5A5);
        check("wr_m0_rdata", bus.m0_rdata, 32'hDEADBEEF);
        tick();

        // Timeout on master 0 with master 1 waiting
        bus.m0_req = 1'b1; bus.m0_addr = 32'h40;
        tick();
        check("to_mem_req_c1", bus.mem_req, 1);
        bus.m1_req = 1'b1; bus.m1_addr = 32'h80;
        for (int i = 0; i < 7; i++) tick();
        check("to_mem_req_c8", bus.mem_req, 1);
        check("to_no_ack_c8",  bus.m0_ack, 0);
        tick();
        bus.m0_req = 1'b0;
        check("to_mem_req_drop", bus.mem_req, 0);
        check("to_m0_ack",   bus.m0_ack, 1);
        check("to_m0_err",   bus.m0_err, 1);
        check("to_m0_rdata", bus.m0_rdata, 0);
        check("to_m1_ack",   bus.m1_ack, 0);
        check("to_m1_err",   bus.m1_err, 0);
        tick();
        check("to_err_clr", bus.m0_err, 0);
        tick();
        check("to_m1_grant", owner, 1);
        check("to_m1_addr",  bus.mem_addr, 32'h80);
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'h11110000;
        tick();
        bus.mem_ack = 1'b0; bus.m1_req = 1'b0;
        check("to_m1_ack",   bus.m1_ack, 1);
        check("to_m1_err_0", bus.m1_err, 0);
        check("to_m1_rdata", bus.m1_rdata, 32'h11110000);
        tick();

        // Ack arriving on the final timeout cycle
        bus.m0_req = 1'b1; bus.m0_addr = 32'h44;
        tick();
        for (int i = 0; i < 7; i++) tick();
        check("col_mem_req_c8", bus.mem_req, 1);
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'hCAFEF00D;
        tick();
        bus.mem_ack = 1'b0; bus.m0_req = 1'b0;
        check("col_m0_ack",   bus.m0_ack, 1);
        check("col_m0_err",   bus.m0_err, 0);
        check("col_m0_rdata", bus.m0_rdata, 32'hCAFEF00D);
        tick();

        // Reset during the 2nd BUSY cycle
        bus.m0_req = 1'b1; bus.m0_addr = 32'h60;
        tick();
        tick();
        check("rmo_busy_before", busy, 1);
        #2 rst = 1'b1;
        #1;
        check("rmo_mem_req", bus.mem_req, 0);
        check("rmo_busy",    busy, 0);
        check("rmo_m0_rdata", bus.m0_rdata, 0);
        bus.m1_req = 1'b1; bus.m1_addr = 32'h90;
        tick();
        rst = 1'b0;
        tick();
        check("rmo_tie_owner", owner, 0);
        check("rmo_tie_addr",  bus.mem_addr, 32'h60);
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'h0BADC0DE;
        tick();
        bus.mem_ack = 1'b0; bus.m0_req = 1'b0; bus.m1_req = 1'b0;
        check("rmo_m0_ack", bus.m0_ack, 1);
        check("rmo_m1_ack", bus.m1_ack, 0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
